// File: rtl/rom_uart_loader.sv
// rom_uart_loader: receives a length-prefixed image over UART and writes it word-by-word into the instruction ROM
module rom_uart_loader #(
  parameter int WAIT   = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              load_we,
  output logic [ADDR_W-1:0] load_addr,
  output logic [31:0]       load_data,
  output logic              cpu_hold,
  output logic              err
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [1:0] {L_LEN0, L_LEN1, L_DATA} ld_t;
  localparam int CW = $clog2(WAIT);
  logic              s1_q, s2_q, prev_q;
  rx_t               rs_q, rs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              byte_valid, frame_err;
  ld_t               ls_q, ls_d;
  logic [15:0]       len_q, len_d, words_q, words_d;
  logic [1:0]        bc_q, bc_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, hold_q, hold_d, err_q, err_d;

  // Two-flop synchronizer plus a delayed copy for start-edge detection; idles high
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1_q, s2_q, prev_q} <= 3'b111;
    else {s1_q, s2_q, prev_q} <= {uart_rx, s1_q, s2_q};

  // State registers for both FSMs and the loader datapath
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rs_q    <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ls_q    <= L_LEN0;
      len_q   <= '0;
      words_q <= '0;
      bc_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ls_q    <= ls_d;
      len_q   <= len_d;
      words_q <= words_d;
      bc_q    <= bc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end

  // UART receiver: mid-bit sampling, glitch rejection on the start bit, framing check on stop
  always_comb begin
    rs_d       = rs_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rs_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) rs_d = R_START;
      end
      R_START:
        if (cnt_q == CW'(WAIT/2 - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          rs_d  = s2_q ? R_IDLE : R_DATA;
        end
      R_DATA:
        if (cnt_q == CW'(WAIT - 1)) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) rs_d = R_STOP;
        end
      R_STOP:
        if (cnt_q == CW'(WAIT - 1)) begin
          cnt_d      = '0;
          byte_valid = s2_q;
          frame_err  = !s2_q;
          rs_d       = R_IDLE;
        end
      default: rs_d = R_IDLE;
    endcase
  end

  // Loader: length prefix, little-endian word assembly, write strobe and address advance
  always_comb begin
    ls_d    = ls_q;
    len_d   = len_q;
    words_d = words_q;
    bc_d    = bc_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    err_d   = err_q;
    if (we_q) begin
      addr_d  = addr_q + 1'b1;
      words_d = words_q + 1'b1;
      if (words_q + 16'd1 == len_q) begin
        hold_d = 1'b0;
        err_d  = 1'b0;
        ls_d   = L_LEN0;
      end
    end
    if (frame_err) begin
      err_d = 1'b1;
      bc_d  = '0;
      ls_d  = L_LEN0;
    end else if (byte_valid)
      case (ls_q)
        L_LEN0: begin
          len_d[7:0] = sh_q;
          hold_d     = 1'b1;
          ls_d       = L_LEN1;
        end
        L_LEN1: begin
          len_d = {sh_q, len_q[7:0]};
          if (len_d == 16'd0) begin
            hold_d = 1'b0;
            err_d  = 1'b0;
            ls_d   = L_LEN0;
          end else begin
            ls_d    = L_DATA;
            words_d = '0;
            addr_d  = '0;
            bc_d    = '0;
          end
        end
        L_DATA: begin
          data_d = {sh_q, data_q[31:8]};
          bc_d   = bc_q + 1'b1;
          we_d   = (bc_q == 2'd3);
        end
        default: ls_d = L_LEN0;
      endcase
  end

  assign load_we   = we_q;
  assign load_addr = addr_q;
  assign load_data = data_q;
  assign cpu_hold  = hold_q;
  assign err       = err_q;
endmodule

// File: doc/rom_uart_loader.md
# rom_uart_loader

UART program loader that receives a length-prefixed program image on `uart_rx` and writes it word-by-word into the instruction ROM. It is the writer side of the ROM the CPU fetches from. It sits on the `mother_board` between the `uart_rx` pin and the ROM write port, and holds the CPU in reset while a load is in progress. With the line idle (`uart_rx` high), the block is inert, so preloaded ROM contents run untouched.

## Interface
Parameters:
- `WAIT`, 8, clocks per UART bit; even, ≥ 4.
- `ADDR_W`, 10, ROM word-address width.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `uart_rx`  input  1  serial input, 8N1, LSB first, idle high.
- `load_we`  output  1  one-cycle ROM write strobe.
- `load_addr`  output  ADDR_W  ROM word address.
- `load_data`  output  32  ROM write data.
- `cpu_hold`  output  1  high while a load is in progress; OR'd into CPU reset by the board.
- `err`  output  1  sticky framing-error flag.

## Operation
- `uart_rx` passes through a 2-flop synchronizer, which resets to 1.
- RX FSM states:
  - R_IDLE: a falling edge goes to R_START.
  - R_START: after WAIT/2 clocks, sample. A 0 goes to R_DATA; a 1 is a glitch, so return to R_IDLE with no byte.
  - R_DATA: sample every WAIT clocks, 8 bits, LSB first, then go to R_STOP.
  - R_STOP: sample after WAIT clocks. A 1 gives `byte_valid` for one cycle. A 0 is a framing error. Either way, return to R_IDLE.
- Loader FSM states:
  - L_LEN0: a byte is the count low byte. Go to L_LEN1 and set `cpu_hold` = 1.
  - L_LEN1: a byte is the count high byte, giving N (16 bit). If N = 0, clear `cpu_hold` and go to L_LEN0. Otherwise go to L_DATA, with word counter = 0 and `load_addr` = 0.
  - L_DATA: collect 4 bytes little-endian, so `load_data` = {b3,b2,b1,b0}.
    - After the 4th byte, pulse `load_we`.
    - The cycle after, increment `load_addr`, which wraps modulo 2^ADDR_W, and increment the word counter.
    - When the counter reaches N, clear `cpu_hold` and go to L_LEN0.
- Framing error in any loader state:
  - Set `err` = 1 and discard the partial word and count.
  - Return to L_LEN0 with `cpu_hold` still 1.
  - `err` clears when the next load completes, i.e. when `cpu_hold` falls normally.
- If a framing error occurs in L_LEN0 while `cpu_hold` = 0, set `err` and leave `cpu_hold` at 0.

## Timing
- Reset values:
  - `load_we` = 0, `load_addr` = 0, `load_data` = 0, `cpu_hold` = 0, `err` = 0.
  - Both FSMs go to their IDLE/LEN0 states and all counters clear.
- Reset mid-load aborts immediately. No write is issued for a partial word.
- Synchronizer latency is 2 clocks. `byte_valid` rises about 9.5·WAIT + 2 clocks after the start-bit edge.
- `load_we` is high exactly 1 cycle, starting 1 cycle after `byte_valid` of the word's 4th byte. `load_addr` and `load_data` are stable during that cycle.
- `cpu_hold` falls 1 cycle after the final `load_we`, or 1 cycle after `byte_valid` of the count high byte when N = 0.
- Back-to-back frames (start bit right after stop bit) must be received without loss.
- N > 2^ADDR_W: addresses wrap and later words overwrite earlier ones; no error.

## Test plan
All scenarios use WAIT = 8.
- Idle line held high for 2000 clocks after reset: `load_we` never pulses; `cpu_hold` = 0 and `err` = 0 throughout.
- Send 02 00 | 00 02 30 00 | 00 23 40 00:
  - Two `load_we` pulses: addr 0 / 0x00300200, then addr 1 / 0x00402300.
  - `cpu_hold` is 1 from the first byte and falls 1 cycle after the 2nd pulse.
  - Releasing the CPU then gives x[2] = 3.
- Send 00 00: `cpu_hold` pulses high between the two bytes; no `load_we`.
- Framing error (stop bit 0) on the 2nd data byte of a 1-word load, then 01 00 | 0A 00 00 00:
  - `err` = 1 and `cpu_hold` = 1 after the bad byte.
  - Then a single write, addr 0 / 0x0000000A.
  - `err` and `cpu_hold` both 0 afterwards.
- A 2-clock low glitch on `uart_rx`: no byte is accepted and all outputs are unchanged.
- Assert `reset` after 2 data bytes of a load:
  - All outputs return to reset values.
  - A following full 1-word load writes addr 0 with the correct data.
